// File: rtl/k_fifo_2deep_ctrl_t1.sv
// Control stage in front of a 2-deep write-priority dual-port RAM; makes it act as a 2-entry
// FIFO with valid/ready on both sides. Reads only happen on cycles with no write.
module k_fifo_2deep_ctrl_t1 #(
  parameter int data_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [data_size-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_size-1:0] ram_d,
  output logic                 ram_wen,
  output logic                 ram_waddr,
  output logic                 ram_raddr,
  input  logic [data_size-1:0] ram_q,
  output logic [1:0]           level
);

  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_occ;
  logic       r_loaded;

  logic       w_push;
  logic       w_pop;
  logic       w_in_ready;

  // An unloaded head blocks writes so the RAM gets its read cycle.
  assign w_in_ready = !rst && (r_occ != 2'd2) && !((r_occ != 2'd0) && !r_loaded);
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = r_loaded && out_ready;

  assign in_ready  = w_in_ready;
  assign ram_wen   = w_push;
  assign ram_d     = in_data;
  assign ram_waddr = r_wptr;
  assign ram_raddr = r_rptr;
  assign out_data  = ram_q;
  assign out_valid = r_loaded;
  assign level     = r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
      r_loaded <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      // q holds across a write, so loaded survives a push-only cycle.
      if (w_pop)
        r_loaded <= 1'b0;
      else if (!w_push && (r_occ != 2'd0))
        r_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_k_fifo_2deep_ctrl_t1.sv
// Directed bench for k_fifo_2deep_ctrl_t1 with a behavioural write-priority 2-entry RAM.
module tb_k_fifo_2deep_ctrl_t1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ram_d;
  logic       ram_wen;
  logic       ram_waddr;
  logic       ram_raddr;
  logic [7:0] ram_q = 8'h00;
  logic [1:0] level;

  logic [7:0] mem [2] = '{8'h00, 8'h00};

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // RAM: write wins; a read happens only on a non-write cycle.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_d;
    else         ram_q <= mem[ram_raddr];
  end

  k_fifo_2deep_ctrl_t1 #(.data_size(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_d(ram_d), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_q(ram_q), .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven, and checks follow a settle delay.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
    settle();
    chk("rst_wen", ram_wen, 0);
    chk("rst_inrdy", in_ready, 0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    settle();
    chk("rst_level", level, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_wen_after", ram_wen, 0);
    chk("rst_inrdy_after", in_ready, 1);
  endtask

  initial begin
    int         pushes;
    int         pops;
    logic [7:0] nxt_in;
    logic [7:0] exp_out;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    do_reset();

    // Single push: latency 2 to out_valid.
    in_valid = 1'b1; in_data = 8'hA5;
    settle();
    chk("t1_wen", ram_wen, 1);
    chk("t1_waddr", ram_waddr, 0);
    step();
    in_valid = 1'b0;
    settle();
    chk("t1_inrdy_c2", in_ready, 0);
    chk("t1_ovalid_c2", out_valid, 0);
    chk("t1_level_c2", level, 1);
    step();
    settle();
    chk("t1_ovalid_c3", out_valid, 1);
    chk("t1_odata_c3", out_data, 8'hA5);
    chk("t1_level_c3", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    settle();
    chk("t1_level_pop", level, 0);
    chk("t1_ovalid_pop", out_valid, 0);

    // Fill to 2 with consumer stalled.
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    settle();
    chk("t2_blocked", in_ready, 0);
    chk("t2_blocked_wen", ram_wen, 0);
    step();
    settle();
    chk("t2_push22", ram_wen, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t2_full_level", level, 2);
      chk("t2_full_inrdy", in_ready, 0);
      chk("t2_hold_data", out_data, 8'h11);
      chk("t2_hold_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("t2_full_inrdy_oready", in_ready, 0);
    chk("t2_first", out_data, 8'h11);
    step();
    settle();
    chk("t2_gap_valid", out_valid, 0);
    chk("t2_gap_level", level, 1);
    step();
    settle();
    chk("t2_second_valid", out_valid, 1);
    chk("t2_second", out_data, 8'h22);
    step();
    out_ready = 1'b0;
    settle();
    chk("t2_level_end", level, 0);

    // Push and pop in the same cycle at occ=1.
    in_valid = 1'b1; in_data = 8'h44;
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    settle();
    chk("t3_inrdy", in_ready, 1);
    chk("t3_head", out_data, 8'h44);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    settle();
    chk("t3_level_same", level, 1);
    chk("t3_gap_valid", out_valid, 0);
    step();
    settle();
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 8'h33);
    chk("t3_level", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    settle();
    chk("t3_level_end", level, 0);

    // Continuous streaming from empty: 1 item per 2 cycles.
    pushes = 0; pops = 0; nxt_in = 8'h00; exp_out = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = nxt_in;
      settle();
      if (in_ready) begin pushes++; nxt_in++; end
      if (out_valid) begin
        chk("t4_stream_data", out_data, exp_out);
        exp_out++; pops++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("t4_pushes", pushes, 10);
    chk("t4_pops_window", pops, 9);
    for (int c = 0; c < 10; c++) begin
      settle();
      if (out_valid) begin
        chk("t4_drain_data", out_data, exp_out);
        exp_out++; pops++;
      end
      step();
    end
    out_ready = 1'b0;
    settle();
    chk("t4_pops_total", pops, 10);
    chk("t4_level_end", level, 0);

    // Reset with two entries stored.
    in_valid = 1'b1; in_data = 8'h77;
    step();
    step();
    in_data = 8'h88;
    settle();
    chk("t6_push88", ram_wen, 1);
    step();
    in_valid = 1'b0;
    settle();
    chk("t6_level_full", level, 2);
    do_reset();
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    step();
    settle();
    chk("t6_first_valid", out_valid, 1);
    chk("t6_first_data", out_data, 8'h5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    settle();
    chk("t6_level_end", level, 0);

    // Pointer wrap from a clean reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      settle();
      chk("t5_wen", ram_wen, 1);
      chk("t5_waddr", ram_waddr, i % 2);
      step();
      in_valid = 1'b0;
      settle();
      chk("t5_raddr", ram_raddr, i % 2);
      step();
      settle();
      chk("t5_valid", out_valid, 1);
      chk("t5_data", out_data, 8'hC0 + i);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    settle();
    chk("t5_level_end", level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
